// File: rtl/cp0_irq_controller.sv
// CP0 interrupt feeder: synchronises four external request lines,
// applies polarity/mode/enable and latches pending state for Cause.IP[7:4].
module cp0_irq_controller #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq_in,
  input  logic        bus_we,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic [3:0]  irq_out
);

  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] sync;
  logic [3:0] pend_q, pend_d;
  logic [3:0] prev_q, prev_d;
  logic [3:0] en_q, en_d;
  logic [3:0] mode_q, mode_d;
  logic [3:0] pol_q, pol_d;

  logic       wr_en, wr_mode, wr_pol, wr_ack;
  logic [3:0] ack, eff, rise;
  logic [3:0] mode_chg, pol_chg, edge_nxt;
  logic [1:0] claim_idx;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign wr_en   = bus_we && (bus_addr == 3'd1);
  assign wr_mode = bus_we && (bus_addr == 3'd2);
  assign wr_pol  = bus_we && (bus_addr == 3'd3);
  assign wr_ack  = bus_we && (bus_addr == 3'd4);
  assign irq_out = pend_q & en_q;

  // Input synchroniser chain for the asynchronous request lines
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++)
        sync_q[k] <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++)
        sync_q[k] <= sync_q[k-1];
    end
  end

  // Next-state for configuration, edge history and pending bits
  always_comb begin
    en_d   = en_q;
    mode_d = mode_q;
    pol_d  = pol_q;
    if (wr_en)   en_d   = bus_wdata[3:0];
    if (wr_mode) mode_d = bus_wdata[3:0];
    if (wr_pol)  pol_d  = bus_wdata[3:0];
    ack      = wr_ack ? bus_wdata[3:0] : 4'b0;
    eff      = sync ^ pol_q;
    rise     = eff & ~prev_q;
    mode_chg = mode_d ^ mode_q;
    pol_chg  = pol_d ^ pol_q;
    // a new edge beats an ACK; a polarity flip drops edge state
    edge_nxt = ((pend_q & ~ack) | rise) & ~pol_chg;
    pend_d   = ((mode_q & edge_nxt) | (~mode_q & eff))
             & ~mode_chg;
    // history follows the new polarity so a flip is not an edge
    prev_d   = sync ^ pol_d;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      prev_q <= '0;
      en_q   <= '0;
      mode_q <= '0;
      pol_q  <= '0;
    end else begin
      pend_q <= pend_d;
      prev_q <= prev_d;
      en_q   <= en_d;
      mode_q <= mode_d;
      pol_q  <= pol_d;
    end
  end

  // Highest-numbered active output for CLAIM
  always_comb begin
    claim_idx = 2'd0;
    if (irq_out[1]) claim_idx = 2'd1;
    if (irq_out[2]) claim_idx = 2'd2;
    if (irq_out[3]) claim_idx = 2'd3;
  end

  // Combinational register read mux
  always_comb begin
    bus_rdata = 32'b0;
    case (bus_addr)
      3'd0: bus_rdata[3:0] = pend_q;
      3'd1: bus_rdata[3:0] = en_q;
      3'd2: bus_rdata[3:0] = mode_q;
      3'd3: bus_rdata[3:0] = pol_q;
      3'd5: begin
        bus_rdata[31]  = |irq_out;
        bus_rdata[1:0] = claim_idx;
      end
      default: bus_rdata = 32'b0;
    endcase
  end

endmodule
